// File: rtl/resp_queue_mwr_engine.sv
// resp_queue_mwr_engine
// Drains the completion response queue into posted memory writes toward the
// PCIe TX engine. Each entry goes to the host ring at base + 4*offset, then
// the ring offset is advanced. After INT_COALESCE entries an MSI-X message
// write is issued unless the host has interrupts blocked.
// Optional build macro: RESP_INT_TIMEOUT_EN adds an idle timeout that raises
// an MSI-X for a partial batch after INT_TIMEOUT idle cycles.
module resp_queue_mwr_engine #(
    parameter int INT_COALESCE = 4,
    parameter int INT_TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        en,
    input  logic        response_queue_empty_i,
    input  logic [31:0] response_queue_data_i,
    output logic        response_queue_rd_en_o,
    input  logic [31:0] response_queue_addr_i,
    input  logic [10:0] response_queue_addr_offset_i,
    output logic        response_queue_addr_offset_cnt_en_o,
    input  logic        interrupt_block_i,
    input  logic [31:0] msg_lower_addr_i,
    input  logic [31:0] msg_upper_addr_i,
    input  logic [31:0] msg_data_i,
    output logic        tx_req_o,
    input  logic        tx_ack_i,
    output logic [63:0] tx_addr_o,
    output logic [31:0] tx_data_o,
    output logic        tx_is_msi_o,
    output logic [7:0]  int_pending_o,
    output logic [31:0] resp_cnt_o
);

    localparam logic [7:0]  COALESCE_LVL = 8'(INT_COALESCE);
    localparam logic [15:0] TIMEOUT_LVL  = 16'(INT_TIMEOUT);

    // Out-of-range parameters are rejected at elaboration.
    if (INT_COALESCE < 1 || INT_COALESCE > 255 || INT_TIMEOUT < 1 || INT_TIMEOUT > 65535) begin : g_bad_param
        $error("resp_queue_mwr_engine: INT_COALESCE or INT_TIMEOUT out of range");
    end

    typedef enum logic [2:0] {IDLE, POP, WAIT, WR, ADV, MSI} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        clr;
    logic        accept;
    logic        msi_due;
    logic        timeout_hit;
    logic [31:0] ring_addr;

    // en low behaves exactly like a synchronous reset.
    assign clr       = srst | ~en;
    // An ack only counts while a request is actually being presented.
    assign accept    = tx_req_o & tx_ack_i;
    // 32-bit wrapping add of the ring base and the entry byte offset.
    assign ring_addr = response_queue_addr_i + {19'b0, response_queue_addr_offset_i, 2'b00};
    assign msi_due   = (~interrupt_block_i & (int_pending_o >= COALESCE_LVL)) | timeout_hit;

`ifdef RESP_INT_TIMEOUT_EN
    logic [15:0] idle_cnt;

    // Count idle cycles while a partial batch is waiting for an interrupt.
    always_ff @(posedge clk) begin
        if (clr) begin
            idle_cnt <= '0;
        end else if (state_nxt == POP || (state == MSI && accept)) begin
            idle_cnt <= '0;
        end else if (state == IDLE && int_pending_o != 8'd0 && response_queue_empty_i &&
                     idle_cnt != 16'hFFFF) begin
            idle_cnt <= idle_cnt + 16'd1;
        end
    end

    assign timeout_hit = ~interrupt_block_i & (idle_cnt >= TIMEOUT_LVL);
`else
    // Without the timeout a partial batch waits for INT_COALESCE entries.
    assign timeout_hit = (TIMEOUT_LVL == 16'd0);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a due interrupt wins over popping another entry.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (msi_due) begin
                    state_nxt = MSI;
                end else if (!response_queue_empty_i) begin
                    state_nxt = POP;
                end
            end
            POP:     state_nxt = WAIT;
            WAIT:    state_nxt = WR;
            WR:      if (accept) state_nxt = ADV;
            ADV:     state_nxt = IDLE;
            MSI:     if (accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered control outputs follow the state being entered.
    always_ff @(posedge clk) begin
        if (clr) begin
            response_queue_rd_en_o              <= 1'b0;
            response_queue_addr_offset_cnt_en_o <= 1'b0;
            tx_req_o                            <= 1'b0;
            tx_is_msi_o                         <= 1'b0;
        end else begin
            response_queue_rd_en_o              <= (state_nxt == POP);
            response_queue_addr_offset_cnt_en_o <= (state_nxt == ADV);
            tx_req_o                            <= (state_nxt == WR) || (state_nxt == MSI);
            tx_is_msi_o                         <= (state_nxt == MSI);
        end
    end

    // Request address/data are captured once and held for the whole request.
    always_ff @(posedge clk) begin
        if (clr) begin
            tx_addr_o <= '0;
            tx_data_o <= '0;
        end else if (state == WAIT) begin
            tx_addr_o <= {32'h0, ring_addr};
            tx_data_o <= response_queue_data_i;
        end else if (state == IDLE && state_nxt == MSI) begin
            tx_addr_o <= {msg_upper_addr_i, msg_lower_addr_i};
            tx_data_o <= msg_data_i;
        end
    end

    // Written-entry totals and pending-interrupt count.
    always_ff @(posedge clk) begin
        if (clr) begin
            resp_cnt_o    <= '0;
            int_pending_o <= '0;
        end else if (state == ADV) begin
            resp_cnt_o <= resp_cnt_o + 32'd1;
            if (int_pending_o != 8'hFF) begin
                int_pending_o <= int_pending_o + 8'd1;
            end
        end else if (state == MSI && accept) begin
            int_pending_o <= '0;
        end
    end

endmodule

// File: tb/tb_resp_queue_mwr_engine.sv
// Directed bench for resp_queue_mwr_engine with INT_COALESCE=4, INT_TIMEOUT=16.
// A small FIFO model feeds the response queue, an auto-responder acks TX
// requests after a programmable number of cycles, and a monitor logs every
// accepted request.
module tb_resp_queue_mwr_engine;

    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic        en = 1'b1;
    logic        response_queue_empty_i;
    logic [31:0] response_queue_data_i = '0;
    logic        response_queue_rd_en_o;
    logic [31:0] response_queue_addr_i = '0;
    logic [10:0] response_queue_addr_offset_i = '0;
    logic        response_queue_addr_offset_cnt_en_o;
    logic        interrupt_block_i = 1'b0;
    logic [31:0] msg_lower_addr_i = 32'hFEE0_0000;
    logic [31:0] msg_upper_addr_i = 32'h0000_0001;
    logic [31:0] msg_data_i = 32'h0000_0042;
    logic        tx_req_o;
    logic        tx_ack_i = 1'b0;
    logic [63:0] tx_addr_o;
    logic [31:0] tx_data_o;
    logic        tx_is_msi_o;
    logic [7:0]  int_pending_o;
    logic [31:0] resp_cnt_o;

    int n_checks = 0;
    int n_fail = 0;

    resp_queue_mwr_engine #(.INT_COALESCE(4), .INT_TIMEOUT(16)) dut (
        .clk(clk), .srst(srst), .en(en),
        .response_queue_empty_i(response_queue_empty_i),
        .response_queue_data_i(response_queue_data_i),
        .response_queue_rd_en_o(response_queue_rd_en_o),
        .response_queue_addr_i(response_queue_addr_i),
        .response_queue_addr_offset_i(response_queue_addr_offset_i),
        .response_queue_addr_offset_cnt_en_o(response_queue_addr_offset_cnt_en_o),
        .interrupt_block_i(interrupt_block_i),
        .msg_lower_addr_i(msg_lower_addr_i),
        .msg_upper_addr_i(msg_upper_addr_i),
        .msg_data_i(msg_data_i),
        .tx_req_o(tx_req_o), .tx_ack_i(tx_ack_i),
        .tx_addr_o(tx_addr_o), .tx_data_o(tx_data_o),
        .tx_is_msi_o(tx_is_msi_o),
        .int_pending_o(int_pending_o),
        .resp_cnt_o(resp_cnt_o)
    );

    always #5 clk = ~clk;

    // Response FIFO model: data valid the cycle after the pop; offset counter
    // owned by the bench as the upstream register would be.
    logic [31:0] fmem [0:63];
    int          wp = 0;
    int          rp = 0;
    logic        off_set = 1'b0;
    logic [10:0] off_val = '0;

    assign response_queue_empty_i = (wp == rp);

    always @(posedge clk) begin
        if (response_queue_rd_en_o) begin
            response_queue_data_i <= fmem[rp[5:0]];
            rp <= rp + 1;
        end
        if (off_set) response_queue_addr_offset_i <= off_val;
        else if (response_queue_addr_offset_cnt_en_o) response_queue_addr_offset_i <= response_queue_addr_offset_i + 11'd1;
    end

    // Auto-responder: ack in the ack_lat-th cycle of a request.
    bit ack_en = 1'b1;
    int ack_lat = 1;
    int held = 0;
    always @(negedge clk) begin
        if (tx_req_o && ack_en) begin
            tx_ack_i = (held + 1 >= ack_lat);
            held = held + 1;
        end else begin
            tx_ack_i = 1'b0;
            held = 0;
        end
    end

    // Monitor of accepted requests.
    int          wr_cnt = 0, msi_cnt = 0, pulse_cnt = 0, wr_at_msi = 0;
    int          cur_cyc = 0, last_cyc = 0;
    bit          cur_stable = 1'b1, last_stable = 1'b1, req_prev = 1'b0;
    logic [63:0] cur_addr = '0, last_addr = '0, msi_addr = '0;
    logic [31:0] cur_data = '0, last_data = '0, msi_data = '0;
    always @(posedge clk) begin
        if (response_queue_addr_offset_cnt_en_o) pulse_cnt = pulse_cnt + 1;
        if (tx_req_o) begin
            if (!req_prev) begin
                cur_cyc = 1; cur_addr = tx_addr_o; cur_data = tx_data_o; cur_stable = 1'b1;
            end else begin
                cur_cyc = cur_cyc + 1;
                if (tx_addr_o !== cur_addr || tx_data_o !== cur_data) cur_stable = 1'b0;
            end
            if (tx_ack_i) begin
                if (tx_is_msi_o) begin
                    msi_cnt = msi_cnt + 1; msi_addr = tx_addr_o; msi_data = tx_data_o; wr_at_msi = wr_cnt;
                end else begin
                    wr_cnt = wr_cnt + 1; last_addr = tx_addr_o; last_data = tx_data_o;
                    last_cyc = cur_cyc; last_stable = cur_stable;
                end
            end
        end
        req_prev = tx_req_o;
    end

    task automatic push(input logic [31:0] v);
        fmem[wp[5:0]] = v;
        wp = wp + 1;
    endtask

    task automatic set_ring(input logic [31:0] base, input logic [10:0] off);
        @(negedge clk);
        response_queue_addr_i = base;
        off_set = 1'b1; off_val = off;
        @(negedge clk);
        off_set = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        srst = 1'b1;
        repeat (2) @(negedge clk);
        srst = 1'b0;
    endtask

    task automatic wait_wr(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (wr_cnt >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_msi(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (msi_cnt >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({tx_req_o, response_queue_rd_en_o, response_queue_addr_offset_cnt_en_o, tx_is_msi_o} !== 4'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {tx_req_o, response_queue_rd_en_o, response_queue_addr_offset_cnt_en_o, tx_is_msi_o});
        end
        n_checks++;
        if (tx_addr_o !== 64'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", tx_addr_o); end
        n_checks++;
        if (tx_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", tx_data_o); end
        n_checks++;
        if (int_pending_o !== 8'd0) begin n_fail++; $display("FAIL reset_pending: got %0d want 0", int_pending_o); end
        n_checks++;
        if (resp_cnt_o !== 32'd0) begin n_fail++; $display("FAIL reset_resp_cnt: got %0d want 0", resp_cnt_o); end
        srst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        int m0, p0;
        ack_lat = 1;
        set_ring(32'h1000_0000, 11'd5);
        m0 = msi_cnt; p0 = pulse_cnt;
        @(negedge clk);
        push(32'hDEAD_0001);
        @(posedge clk); #1;
        n_checks++;
        if (response_queue_rd_en_o !== 1'b1) begin n_fail++; $display("FAIL single_rd_en_t1: got %b want 1", response_queue_rd_en_o); end
        @(posedge clk); #1;
        n_checks++;
        if ({response_queue_rd_en_o, tx_req_o} !== 2'b00) begin n_fail++; $display("FAIL single_t2: got %b want 00", {response_queue_rd_en_o, tx_req_o}); end
        @(posedge clk); #1;
        n_checks++;
        if (tx_req_o !== 1'b1 || tx_is_msi_o !== 1'b0) begin n_fail++; $display("FAIL single_req_t3: got req=%b msi=%b want 1 0", tx_req_o, tx_is_msi_o); end
        n_checks++;
        if (tx_addr_o !== 64'h0000_0000_1000_0014) begin n_fail++; $display("FAIL single_addr: got %h want 0000000010000014", tx_addr_o); end
        n_checks++;
        if (tx_data_o !== 32'hDEAD_0001) begin n_fail++; $display("FAIL single_data: got %h want dead0001", tx_data_o); end
        @(posedge clk); #1;
        n_checks++;
        if ({response_queue_addr_offset_cnt_en_o, tx_req_o} !== 2'b10) begin n_fail++; $display("FAIL single_t4: got cnt_en,req=%b want 10", {response_queue_addr_offset_cnt_en_o, tx_req_o}); end
        @(posedge clk); #1;
        n_checks++;
        if (response_queue_addr_offset_cnt_en_o !== 1'b0 || int_pending_o !== 8'd1 || resp_cnt_o !== 32'd1) begin
            n_fail++; $display("FAIL single_t5: got cnt_en=%b pend=%0d cnt=%0d want 0 1 1", response_queue_addr_offset_cnt_en_o, int_pending_o, resp_cnt_o);
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (msi_cnt - m0 !== 0 || pulse_cnt - p0 !== 1) begin n_fail++; $display("FAIL single_counts: got msi=%0d pulses=%0d want 0 1", msi_cnt - m0, pulse_cnt - p0); end
    endtask

    task automatic test_coalesce();
        int w0, m0;
        bit ok;
        do_reset();
        set_ring(32'h2000_0000, 11'd0);
        w0 = wr_cnt; m0 = msi_cnt;
        @(negedge clk);
        push(32'h1111_0000); push(32'h2222_0001); push(32'h3333_0002); push(32'h4444_0003);
        wait_msi(m0 + 1, 200, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL coalesce_msi_seen: got none want 1 MSI"); end
        repeat (5) @(negedge clk);
        n_checks++;
        if (wr_at_msi - w0 !== 4 || wr_cnt - w0 !== 4) begin n_fail++; $display("FAIL coalesce_writes: got before_msi=%0d total=%0d want 4 4", wr_at_msi - w0, wr_cnt - w0); end
        n_checks++;
        if (last_addr !== 64'h0000_0000_2000_000C || last_data !== 32'h4444_0003) begin n_fail++; $display("FAIL coalesce_last: got %h/%h want 000000002000000c/44440003", last_addr, last_data); end
        n_checks++;
        if (msi_addr !== 64'h0000_0001_FEE0_0000 || msi_data !== 32'h0000_0042) begin n_fail++; $display("FAIL coalesce_msi: got %h/%h want 00000001fee00000/00000042", msi_addr, msi_data); end
        n_checks++;
        if (int_pending_o !== 8'd0 || resp_cnt_o !== 32'd4) begin n_fail++; $display("FAIL coalesce_cnt: got pend=%0d cnt=%0d want 0 4", int_pending_o, resp_cnt_o); end
    endtask

    task automatic test_block();
        int w0, m0;
        bit ok;
        do_reset();
        interrupt_block_i = 1'b1;
        w0 = wr_cnt; m0 = msi_cnt;
        for (int i = 0; i < 6; i++) push(32'hB10C_0000 + i);
        wait_wr(w0 + 6, 300, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL block_writes: got %0d want 6", wr_cnt - w0); end
        repeat (30) @(negedge clk);
        n_checks++;
        if (msi_cnt - m0 !== 0 || int_pending_o !== 8'd6 || resp_cnt_o !== 32'd6) begin
            n_fail++; $display("FAIL block_held: got msi=%0d pend=%0d cnt=%0d want 0 6 6", msi_cnt - m0, int_pending_o, resp_cnt_o);
        end
        interrupt_block_i = 1'b0;
        wait_msi(m0 + 1, 50, ok);
        repeat (20) @(negedge clk);
        n_checks++;
        if (msi_cnt - m0 !== 1 || int_pending_o !== 8'd0) begin n_fail++; $display("FAIL block_release: got msi=%0d pend=%0d want 1 0", msi_cnt - m0, int_pending_o); end
    endtask

    task automatic test_backpressure_wrap();
        int w0;
        bit ok;
        do_reset();
        ack_lat = 7;
        set_ring(32'hFFFF_FFF8, 11'd3);
        w0 = wr_cnt;
        push(32'hCAFE_0003);
        wait_wr(w0 + 1, 60, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL bp_write_seen: got none want 1"); end
        n_checks++;
        if (last_cyc !== 7 || last_stable !== 1'b1) begin n_fail++; $display("FAIL bp_hold: got cycles=%0d stable=%0d want 7 1", last_cyc, last_stable); end
        n_checks++;
        if (last_addr !== 64'h0000_0000_0000_0004 || last_data !== 32'hCAFE_0003) begin n_fail++; $display("FAIL bp_wrap_addr: got %h/%h want 0000000000000004/cafe0003", last_addr, last_data); end
        ack_lat = 1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_request();
        int w0;
        bit ok;
        ack_en = 1'b0;
        w0 = wr_cnt;
        push(32'hAAAA_0001); push(32'hBBBB_0002);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_req_o) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok || tx_data_o !== 32'hAAAA_0001) begin n_fail++; $display("FAIL mid_req_up: got req=%0d data=%h want 1 aaaa0001", ok, tx_data_o); end
        srst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (tx_req_o !== 1'b0 || int_pending_o !== 8'd0 || resp_cnt_o !== 32'd0) begin
            n_fail++; $display("FAIL mid_req_reset: got req=%b pend=%0d cnt=%0d want 0 0 0", tx_req_o, int_pending_o, resp_cnt_o);
        end
        @(negedge clk);
        srst = 1'b0;
        ack_en = 1'b1;
        wait_wr(w0 + 1, 60, ok);
        repeat (3) @(negedge clk);
        n_checks++;
        if (!ok || last_data !== 32'hBBBB_0002 || last_addr !== 64'h0000_0000_0000_0008) begin
            n_fail++; $display("FAIL mid_req_next: got ok=%0d %h/%h want 1 0000000000000008/bbbb0002", ok, last_addr, last_data);
        end
        n_checks++;
        if (resp_cnt_o !== 32'd1 || wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL mid_req_cnt: got cnt=%0d writes=%0d want 1 1", resp_cnt_o, wr_cnt - w0); end
    endtask

    task automatic test_timeout();
        int k;
        bit ok;
        do_reset();
        set_ring(32'h3000_0000, 11'd0);
        push(32'h7100_0001);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (response_queue_addr_offset_cnt_en_o) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL timeout_write: got no cnt_en want 1"); end
        k = 0;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            k++;
            if (tx_req_o && tx_is_msi_o) begin ok = 1'b1; break; end
        end
`ifdef RESP_INT_TIMEOUT_EN
        // ADV cycle is k=0, IDLE entered at k=1; MSI request 16..17 cycles later.
        n_checks++;
        if (!ok || k < 17 || k > 18) begin n_fail++; $display("FAIL timeout_msi: got seen=%0d at=%0d want 1 at 17..18", ok, k); end
`else
        n_checks++;
        if (ok || int_pending_o !== 8'd1) begin n_fail++; $display("FAIL timeout_absent: got msi=%0d pend=%0d want 0 1", ok, int_pending_o); end
`endif
    endtask

    task automatic test_enable();
        int w0;
        bit ok;
        w0 = wr_cnt;
        push(32'hE0E0_0001);
        wait_wr(w0 + 1, 60, ok);
        repeat (3) @(negedge clk);
        en = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (int_pending_o !== 8'd0 || resp_cnt_o !== 32'd0 || tx_req_o !== 1'b0) begin
            n_fail++; $display("FAIL enable_low: got pend=%0d cnt=%0d req=%b want 0 0 0", int_pending_o, resp_cnt_o, tx_req_o);
        end
        @(negedge clk);
        en = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_coalesce();
        test_block();
        test_backpressure_wrap();
        test_reset_mid_request();
        test_timeout();
        test_enable();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
